// File: rtl/video_timing_pkg.sv
// Shared types and default 640x480@60 timing for the nn_rgb video timing generator.
package video_timing_pkg;

  typedef enum logic [1:0] {ACTIVE, FRONT, SYNC, BACK} vt_phase_t;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam bit DEF_HS_POL   = 1'b0;
  localparam bit DEF_VS_POL   = 1'b0;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/video_timing_if.sv
// vs/hs/de sync bundle with pixel coordinates and start pulses, as passed down the nn_rgb pipeline.
interface video_timing_if #(
  parameter int XW = 10,
  parameter int YW = 9
);
  logic          vs_out;
  logic          hs_out;
  logic          de_out;
  logic [XW-1:0] x_out;
  logic [YW-1:0] y_out;
  logic          frame_start;
  logic          line_start;

  modport master (output vs_out, hs_out, de_out, x_out, y_out, frame_start, line_start);
  modport slave  (input  vs_out, hs_out, de_out, x_out, y_out, frame_start, line_start);
endinterface

// File: rtl/vtg_axis_counter.sv
// One raster axis: a position counter plus a phase register (ACTIVE/FRONT/SYNC/BACK) that tracks it.
module vtg_axis_counter #(
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48,
  parameter int CW     = 10
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        step,
  output logic [CW-1:0]               cnt,
  output video_timing_pkg::vt_phase_t phase,
  output logic                        wrap
);

  localparam int TOTAL = ACTIVE + FP + SYNC + BP;
  localparam logic [CW-1:0] LAST_ACTIVE = CW'(ACTIVE - 1);
  localparam logic [CW-1:0] LAST_FRONT  = CW'(ACTIVE + FP - 1);
  localparam logic [CW-1:0] LAST_SYNC   = CW'(ACTIVE + FP + SYNC - 1);
  localparam logic [CW-1:0] LAST        = CW'(TOTAL - 1);

  logic [CW-1:0]               cnt_next;
  video_timing_pkg::vt_phase_t phase_next;

  assign wrap = (cnt == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt   <= '0;
      phase <= video_timing_pkg::ACTIVE;
    end else if (step) begin
      cnt   <= cnt_next;
      phase <= phase_next;
    end
  end

  // The phase always describes the current count, so it moves on the last count of each region.
  always_comb begin
    cnt_next   = wrap ? '0 : cnt + 1'b1;
    phase_next = phase;
    case (phase)
      video_timing_pkg::ACTIVE: if (cnt == LAST_ACTIVE) phase_next = video_timing_pkg::FRONT;
      video_timing_pkg::FRONT:  if (cnt == LAST_FRONT)  phase_next = video_timing_pkg::SYNC;
      video_timing_pkg::SYNC:   if (cnt == LAST_SYNC)   phase_next = video_timing_pkg::BACK;
      video_timing_pkg::BACK:   if (wrap)               phase_next = video_timing_pkg::ACTIVE;
      default:                                          phase_next = video_timing_pkg::ACTIVE;
    endcase
  end

endmodule

// File: rtl/video_timing_gen.sv
// Parameterised progressive raster timing source: registered vs/hs/de, pixel coordinates and start pulses.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit HS_POL   = DEF_HS_POL,
  parameter bit VS_POL   = DEF_VS_POL
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           en,
  video_timing_if.master vid
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int CW      = $clog2(max_int(H_TOTAL, V_TOTAL));
  localparam int XW      = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int YW      = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;

  if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_param_check
    $fatal(1, "video_timing_gen: every timing parameter must be >= 1");
  end

  logic [CW-1:0] h_cnt, v_cnt;
  vt_phase_t     h_phase, v_phase;
  logic          h_wrap, v_wrap_unused;
  logic          v_step;
  logic          de_next;

  assign v_step  = en && h_wrap;
  assign de_next = (h_phase == ACTIVE) && (v_phase == ACTIVE);

  vtg_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .CW(CW)
  ) u_h_axis (
    .clk(clk), .reset(reset), .step(en),
    .cnt(h_cnt), .phase(h_phase), .wrap(h_wrap)
  );

  vtg_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .CW(CW)
  ) u_v_axis (
    .clk(clk), .reset(reset), .step(v_step),
    .cnt(v_cnt), .phase(v_phase), .wrap(v_wrap_unused)
  );

  // Outputs trail the counters by one edge; with en low everything freezes except the pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vid.de_out      <= 1'b0;
      vid.hs_out      <= ~HS_POL;
      vid.vs_out      <= ~VS_POL;
      vid.x_out       <= '0;
      vid.y_out       <= '0;
      vid.frame_start <= 1'b0;
      vid.line_start  <= 1'b0;
    end else if (en) begin
      vid.de_out      <= de_next;
      vid.hs_out      <= (h_phase == SYNC) ? HS_POL : ~HS_POL;
      vid.vs_out      <= (v_phase == SYNC) ? VS_POL : ~VS_POL;
      vid.x_out       <= de_next ? h_cnt[XW-1:0] : '0;
      vid.y_out       <= de_next ? v_cnt[YW-1:0] : '0;
      vid.frame_start <= (h_cnt == '0) && (v_cnt == '0);
      vid.line_start  <= (h_cnt == '0) && (v_phase == ACTIVE);
    end else begin
      vid.frame_start <= 1'b0;
      vid.line_start  <= 1'b0;
    end
  end

endmodule
